// File: rtl/oam_pkg.sv
// rtl/oam_pkg.sv - shared types and defaults for the OAM double buffer
package oam_pkg;

    // Controller states: idle, sweeping the back bank, swap queued behind a clear
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_PEND = 2'd2
    } oam_state_e;

    // Off-screen Y coordinate; a cleared sprite never appears on a scanline
    localparam logic [15:0] OAM_CLEAR_VALUE = 16'hFFFF;

endpackage

// File: rtl/oam_bank.sv
// rtl/oam_bank.sv - one OAM bank: WORDS 16-bit simple-dual-port lanes, registered read
module oam_bank
    import oam_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int WORDS   = 2,
    parameter int EAW     = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORDS-1:0]      we,
    input  logic [EAW-1:0]        waddr,
    input  logic [15:0]           wdata,
    input  logic                  re,
    input  logic [EAW-1:0]        raddr,
    output logic [16*WORDS-1:0]   rdata
);

    for (genvar g = 0; g < WORDS; g++) begin : g_lane
        logic [15:0] mem [ENTRIES];
        logic [15:0] rd_d;
        logic [15:0] rd_q;

        // Lane storage is deliberately not reset so contents survive a reset
        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem[waddr] <= wdata;
            end
        end

        // Read register only loads on a strobe so the output holds between reads
        always_comb begin
            rd_d = rd_q;
            if (re) begin
                rd_d = mem[raddr];
            end
        end

        // Read register clears on reset so the top presents zero data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rdata[16*g +: 16] = rd_q;
    end

endmodule

// File: rtl/oam_double_buffer.sv
// rtl/oam_double_buffer.sv - double-buffered sprite attribute memory with clear engine
module oam_double_buffer
    import oam_pkg::*;
#(
    parameter int          ENTRIES     = 64,
    parameter int          WORDS       = 2,
    parameter logic [15:0] CLEAR_VALUE = OAM_CLEAR_VALUE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(ENTRIES*WORDS)-1:0]  write_addr,
    input  logic [15:0]                       write_data,
    input  logic                              write_enable,
    input  logic [$clog2(ENTRIES)-1:0]        read_addr,
    input  logic                              read_enable,
    output logic [16*WORDS-1:0]               read_data,
    output logic                              read_valid,
    input  logic                              swap_req,
    input  logic                              clear_req,
    output logic                              busy,
    output logic                              front_bank,
    output logic                              swap_done,
    output logic                              write_dropped
);

    localparam int AW  = $clog2(ENTRIES*WORDS);
    localparam int EAW = $clog2(ENTRIES);
    localparam int LB  = $clog2(WORDS);

    oam_state_e       state_q, state_d;
    logic             front_q, front_d;
    logic             pend_q, pend_d;
    logic [EAW-1:0]   cnt_q, cnt_d;
    logic             swap_done_q, swap_done_d;
    logic             dropped_q, dropped_d;
    logic             read_valid_q, read_valid_d;
    logic             read_bank_q, read_bank_d;

    logic [EAW-1:0]   write_entry;
    logic [WORDS-1:0] lane_sel;
    logic [WORDS-1:0] bank_we;
    logic [EAW-1:0]   bank_waddr;
    logic [15:0]      bank_wdata;
    logic [16*WORDS-1:0] rdata0, rdata1;

    // Split the word address into entry index and one-hot lane select
    always_comb begin
        write_entry = EAW'(write_addr >> LB);
        for (int i = 0; i < WORDS; i++) begin
            lane_sel[i] = ((write_addr & AW'(WORDS-1)) == AW'(i));
        end
    end

    // Controller: host writes and swaps in idle, one entry per cycle while clearing
    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        swap_done_d  = 1'b0;
        dropped_d    = 1'b0;
        bank_we      = '0;
        bank_waddr   = write_entry;
        bank_wdata   = write_data;
        read_valid_d = read_enable;
        read_bank_d  = read_enable ? front_q : read_bank_q;
        case (state_q)
            ST_IDLE: begin
                if (write_enable) begin
                    bank_we = lane_sel;
                end
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    pend_d  = swap_req;
                end else if (swap_req) begin
                    front_d     = ~front_q;
                    swap_done_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                bank_we    = '1;
                bank_waddr = cnt_q;
                bank_wdata = CLEAR_VALUE;
                dropped_d  = write_enable;
                if (swap_req) begin
                    pend_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == EAW'(ENTRIES-1)) begin
                    cnt_d   = '0;
                    state_d = (pend_q || swap_req) ? ST_SWAP_PEND : ST_IDLE;
                end
            end
            ST_SWAP_PEND: begin
                dropped_d   = write_enable;
                front_d     = ~front_q;
                swap_done_d = 1'b1;
                pend_d      = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and read-qualifier state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            swap_done_q  <= 1'b0;
            dropped_q    <= 1'b0;
            read_valid_q <= 1'b0;
            read_bank_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            swap_done_q  <= swap_done_d;
            dropped_q    <= dropped_d;
            read_valid_q <= read_valid_d;
            read_bank_q  <= read_bank_d;
        end
    end

    oam_bank #(.ENTRIES(ENTRIES), .WORDS(WORDS)) u_bank0 (
        .clk   (clk),
        .rst   (reset),
        .we    (front_q ? bank_we : '0),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (read_enable && !front_q),
        .raddr (read_addr),
        .rdata (rdata0)
    );

    oam_bank #(.ENTRIES(ENTRIES), .WORDS(WORDS)) u_bank1 (
        .clk   (clk),
        .rst   (reset),
        .we    (front_q ? '0 : bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (read_enable && front_q),
        .raddr (read_addr),
        .rdata (rdata1)
    );

    assign read_data     = read_bank_q ? rdata1 : rdata0;
    assign read_valid    = read_valid_q;
    assign busy          = (state_q != ST_IDLE);
    assign front_bank    = front_q;
    assign swap_done     = swap_done_q;
    assign write_dropped = dropped_q;

endmodule

// File: tb/tb_oam_double_buffer.sv
// tb/tb_oam_double_buffer.sv - directed self-checking bench for oam_double_buffer
module tb_oam_double_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  write_addr;
    logic [15:0] write_data;
    logic        write_enable;
    logic [5:0]  read_addr;
    logic        read_enable;
    logic [31:0] read_data;
    logic        read_valid;
    logic        swap_req;
    logic        clear_req;
    logic        busy;
    logic        front_bank;
    logic        swap_done;
    logic        write_dropped;

    int errors = 0;
    int checks = 0;

    int busy_cnt;
    int drop_cnt;
    int drop_at;
    int sd_cnt;
    int sd_at;

    oam_double_buffer #(.ENTRIES(64), .WORDS(2), .CLEAR_VALUE(16'hFFFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_addr     (read_addr),
        .read_enable   (read_enable),
        .read_data     (read_data),
        .read_valid    (read_valid),
        .swap_req      (swap_req),
        .clear_req     (clear_req),
        .busy          (busy),
        .front_bank    (front_bank),
        .swap_done     (swap_done),
        .write_dropped (write_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        swap_req     = 1'b0;
        clear_req    = 1'b0;
    endtask

    task automatic read_entry(input logic [5:0] a);
        read_addr   = a;
        read_enable = 1'b1;
        step();
        read_enable = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        write_addr = '0;
        write_data = '0;
        read_addr  = '0;
        idle_inputs();
        step();
        step();
        check_eq("rst_busy",       32'(busy), 32'd0);
        check_eq("rst_front",      32'(front_bank), 32'd0);
        check_eq("rst_valid",      32'(read_valid), 32'd0);
        check_eq("rst_data",       read_data, 32'h0);
        check_eq("rst_swap_done",  32'(swap_done), 32'd0);
        check_eq("rst_dropped",    32'(write_dropped), 32'd0);
        reset = 1'b0;
        step();

        // Fill entry 0 of back bank 1; second write rides with the swap
        write_enable = 1'b1; write_addr = 7'd0; write_data = 16'h1111;
        step();
        write_addr = 7'd1; write_data = 16'h2222; swap_req = 1'b1;
        step();
        idle_inputs();
        check_eq("swap_done_pulse", 32'(swap_done), 32'd1);
        check_eq("front_after_swap", 32'(front_bank), 32'd1);
        check_eq("valid_idle", 32'(read_valid), 32'd0);
        step();
        check_eq("swap_done_one_cycle", 32'(swap_done), 32'd0);
        read_entry(6'd0);
        check_eq("rd_valid_e0", 32'(read_valid), 32'd1);
        check_eq("rd_data_e0", read_data, 32'h2222_1111);
        step();
        check_eq("rd_valid_drop", 32'(read_valid), 32'd0);
        check_eq("rd_data_hold", read_data, 32'h2222_1111);

        // Clear back bank 0, with a dropped write and an ignored second clear
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy_cnt = 0; drop_cnt = 0; drop_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (busy) busy_cnt++;
            if (write_dropped) begin drop_cnt++; drop_at = c; end
            write_enable = (c == 10);
            write_addr   = 7'd10;
            write_data   = 16'h1234;
            clear_req    = (c == 30);
            step();
        end
        idle_inputs();
        check_eq("clear_busy_cycles", 32'(busy_cnt), 32'd64);
        check_eq("drop_count", 32'(drop_cnt), 32'd1);
        check_eq("drop_cycle", 32'(drop_at), 32'd11);
        check_eq("front_kept", 32'(front_bank), 32'd1);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_eq("front_to_0", 32'(front_bank), 32'd0);
        for (int e = 0; e < 64; e++) begin
            read_entry(6'(e));
            check_eq($sformatf("clr_e%0d", e), read_data, 32'hFFFF_FFFF);
        end

        // Clear bank 1 with a swap queued in the same cycle plus a repeat
        clear_req = 1'b1; swap_req = 1'b1;
        step();
        idle_inputs();
        busy_cnt = 0; sd_cnt = 0; sd_at = -1;
        for (int c = 0; c < 100; c++) begin
            if (busy) busy_cnt++;
            if (swap_done) begin sd_cnt++; sd_at = c; end
            swap_req = (c == 20);
            step();
        end
        idle_inputs();
        check_eq("cs_busy_cycles", 32'(busy_cnt), 32'd65);
        check_eq("cs_swap_count", 32'(sd_cnt), 32'd1);
        check_eq("cs_swap_cycle", 32'(sd_at), 32'd65);
        check_eq("cs_front", 32'(front_bank), 32'd1);
        read_entry(6'd0);
        check_eq("cs_e0_cleared", read_data, 32'hFFFF_FFFF);

        // Read in the swap cycle sees the old front bank
        write_enable = 1'b1; write_addr = 7'd6; write_data = 16'hAAAA;
        step();
        write_addr = 7'd7; write_data = 16'hBBBB;
        step();
        write_enable = 1'b0;
        swap_req = 1'b1; read_addr = 6'd3; read_enable = 1'b1;
        step();
        idle_inputs();
        check_eq("swapcyc_front", 32'(front_bank), 32'd0);
        check_eq("swapcyc_data_old", read_data, 32'hFFFF_FFFF);
        read_entry(6'd3);
        check_eq("new_front_data", read_data, 32'hBBBB_AAAA);

        // Reset in the middle of a clear
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check_eq("pre_rst_front", 32'(front_bank), 32'd1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        read_entry(6'd0);
        check_eq("pre_rst_valid", 32'(read_valid), 32'd1);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_front", 32'(front_bank), 32'd0);
        check_eq("mid_rst_valid", 32'(read_valid), 32'd0);
        check_eq("mid_rst_data", read_data, 32'h0);
        check_eq("mid_rst_swap_done", 32'(swap_done), 32'd0);
        check_eq("mid_rst_dropped", 32'(write_dropped), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
